// File: rtl/seq_calc_bcd.sv
// Sequential calculator: shift-add multiply, restoring divide, double-dabble BCD, 7-segment outputs.
// Build macro LEADING_ZERO_BLANK_EN blanks result/remainder digits above the top nonzero digit.
module seq_calc_bcd #(
    parameter int WIDTH      = 4,
    parameter int RES_DIGITS = 3,
    parameter int REM_DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
    input  logic [1:0]              op,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    ovf,
    output logic [1:0]              lop,
    output logic [6:0]              seg_sign,
    output logic [7*RES_DIGITS-1:0] seg_res,
    output logic [7*REM_DIGITS-1:0] seg_rem
);
    localparam int RW = 2*WIDTH;
    localparam int CW = $clog2(RW+1);
    localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11;
    localparam logic [6:0] SEG_MINUS = 7'b0111111, SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_CONV, S_DONE} state_t;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'b1000000;
            4'd1: seg7 = 7'b1111001;
            4'd2: seg7 = 7'b0100100;
            4'd3: seg7 = 7'b0110000;
            4'd4: seg7 = 7'b0011001;
            4'd5: seg7 = 7'b0010010;
            4'd6: seg7 = 7'b0000010;
            4'd7: seg7 = 7'b1111000;
            4'd8: seg7 = 7'b0000000;
            4'd9: seg7 = 7'b0011000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // Clamped exponents keep the limits exact: a 16-bit result never reaches 10^5.
    localparam logic [63:0] RES_LIM = pow10((RES_DIGITS > 5) ? 5 : RES_DIGITS);
    localparam logic [63:0] REM_LIM = pow10((REM_DIGITS > 3) ? 3 : REM_DIGITS);

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q;
    logic [WIDTH-1:0]        a_q, b_q, rem_q;
    logic [1:0]              op_q;
    logic [RW-1:0]           res_q, mcand_q;
    logic                    neg_q, dz_q, res_ovf_q, rem_ovf_q;
    logic [4*RES_DIGITS-1:0] rbcd_q, rbcd_adj;
    logic [4*REM_DIGITS-1:0] mbcd_q, mbcd_adj;
    logic                    calc_last, conv_last;
    logic [WIDTH:0]          div_trial;
    logic [WIDTH-1:0]        div_diff;
    logic                    div_ge;

    logic                    done_q, err_q, ovf_q;
    logic [1:0]              lop_q;
    logic [6:0]              seg_sign_q, seg_sign_d;
    logic [7*RES_DIGITS-1:0] seg_res_q, seg_res_d;
    logic [7*REM_DIGITS-1:0] seg_rem_q, seg_rem_d;
`ifdef LEADING_ZERO_BLANK_EN
    logic                    res_lz, rem_lz;
`endif

    assign calc_last = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                       ((op_q == OP_DIV) && (b_q == '0)) || (cnt_q == CW'(WIDTH-1));
    assign conv_last = (cnt_q == CW'(RW-1));

    // Restoring divide: quotient bits shift into the low WIDTH bits of res_q.
    assign div_trial = {rem_q, res_q[WIDTH-1]};
    assign div_ge    = (div_trial >= {1'b0, b_q});
    assign div_diff  = div_trial[WIDTH-1:0] - b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CALC;
            S_CALC:  if (calc_last) state_d = S_CONV;
            S_CONV:  if (conv_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_CALC) || (state_q == S_CONV);
    end

    always_comb begin
        rbcd_adj = rbcd_q;
        for (int i = 0; i < RES_DIGITS; i++)
            if (rbcd_q[4*i +: 4] >= 4'd5) rbcd_adj[4*i +: 4] = rbcd_q[4*i +: 4] + 4'd3;
        mbcd_adj = mbcd_q;
        for (int i = 0; i < REM_DIGITS; i++)
            if (mbcd_q[4*i +: 4] >= 4'd5) mbcd_adj[4*i +: 4] = mbcd_q[4*i +: 4] + 4'd3;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            res_q     <= '0;
            mcand_q   <= '0;
            rem_q     <= '0;
            neg_q     <= 1'b0;
            dz_q      <= 1'b0;
            res_ovf_q <= 1'b0;
            rem_ovf_q <= 1'b0;
            rbcd_q    <= '0;
            mbcd_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    a_q     <= a;
                    b_q     <= b;
                    op_q    <= op;
                    cnt_q   <= '0;
                    res_q   <= (op == OP_DIV) ? {{WIDTH{1'b0}}, a} : '0;
                    mcand_q <= {{WIDTH{1'b0}}, a};
                    rem_q   <= '0;
                    neg_q   <= 1'b0;
                    dz_q    <= 1'b0;
                    rbcd_q  <= '0;
                    mbcd_q  <= '0;
                end
                S_CALC: begin
                    cnt_q <= calc_last ? '0 : cnt_q + 1'b1;
                    case (op_q)
                        OP_ADD: res_q <= {{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q};
                        OP_SUB: begin
                            if (a_q >= b_q) res_q <= {{WIDTH{1'b0}}, a_q - b_q};
                            else begin
                                res_q <= {{WIDTH{1'b0}}, b_q - a_q};
                                neg_q <= 1'b1;
                            end
                        end
                        OP_MUL: begin
                            if (b_q[0]) res_q <= res_q + mcand_q;
                            mcand_q <= mcand_q << 1;
                            b_q     <= b_q >> 1;
                        end
                        default: begin
                            if (b_q == '0) begin
                                res_q <= '0;
                                rem_q <= '0;
                                dz_q  <= 1'b1;
                            end else begin
                                rem_q <= div_ge ? div_diff : div_trial[WIDTH-1:0];
                                res_q <= {{WIDTH{1'b0}}, res_q[WIDTH-2:0], div_ge};
                            end
                        end
                    endcase
                end
                S_CONV: begin
                    cnt_q <= conv_last ? '0 : cnt_q + 1'b1;
                    if (cnt_q == '0) begin
                        res_ovf_q <= (64'(res_q) >= RES_LIM);
                        rem_ovf_q <= (64'(rem_q) >= REM_LIM);
                    end
                    rbcd_q <= {rbcd_adj[4*RES_DIGITS-2:0], res_q[RW-1]};
                    res_q  <= res_q << 1;
                    // Remainder is only WIDTH bits, so it completes halfway and holds.
                    if (cnt_q < CW'(WIDTH)) begin
                        mbcd_q <= {mbcd_adj[4*REM_DIGITS-2:0], rem_q[WIDTH-1]};
                        rem_q  <= rem_q << 1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < RES_DIGITS; i++) seg_res_d[7*i +: 7] = seg7(rbcd_q[4*i +: 4]);
        for (int i = 0; i < REM_DIGITS; i++) seg_rem_d[7*i +: 7] = seg7(mbcd_q[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
        res_lz = 1'b1;
        for (int i = RES_DIGITS-1; i >= 1; i--) begin
            if (rbcd_q[4*i +: 4] != 4'd0) res_lz = 1'b0;
            if (res_lz) seg_res_d[7*i +: 7] = SEG_BLANK;
        end
        rem_lz = 1'b1;
        for (int i = REM_DIGITS-1; i >= 1; i--) begin
            if (mbcd_q[4*i +: 4] != 4'd0) rem_lz = 1'b0;
            if (rem_lz) seg_rem_d[7*i +: 7] = SEG_BLANK;
        end
`endif
        if (res_ovf_q) seg_res_d = {RES_DIGITS{SEG_MINUS}};
        if (dz_q)      seg_res_d = {RES_DIGITS{SEG_BLANK}};
        if (rem_ovf_q) seg_rem_d = {REM_DIGITS{SEG_MINUS}};
        if (dz_q || (op_q != OP_DIV)) seg_rem_d = {REM_DIGITS{SEG_BLANK}};
        seg_sign_d = (neg_q && !dz_q) ? SEG_MINUS : SEG_BLANK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
            lop_q      <= 2'b00;
            seg_sign_q <= SEG_BLANK;
            seg_res_q  <= {RES_DIGITS{SEG_BLANK}};
            seg_rem_q  <= {REM_DIGITS{SEG_BLANK}};
        end else begin
            done_q <= (state_q == S_DONE);
            if (state_q == S_DONE) begin
                err_q      <= dz_q;
                ovf_q      <= res_ovf_q | rem_ovf_q;
                lop_q      <= op_q;
                seg_sign_q <= seg_sign_d;
                seg_res_q  <= seg_res_d;
                seg_rem_q  <= seg_rem_d;
            end
        end
    end

    assign done     = done_q;
    assign err      = err_q;
    assign ovf      = ovf_q;
    assign lop      = lop_q;
    assign seg_sign = seg_sign_q;
    assign seg_res  = seg_res_q;
    assign seg_rem  = seg_rem_q;
endmodule

// File: tb/tb_seq_calc_bcd.sv
// Bench for seq_calc_bcd: directed plan steps plus random operations against an arithmetic model.
module tb_seq_calc_bcd;
    localparam int W = 4, RD = 3, MD = 2;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [W-1:0]  a, b;
    logic [1:0]    op;
    logic          busy, done, err, ovf;
    logic [1:0]    lop;
    logic [6:0]    seg_sign;
    logic [7*RD-1:0] seg_res;
    logic [7*MD-1:0] seg_rem;

    int checks = 0, failures = 0;
    logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

    seq_calc_bcd #(.WIDTH(W), .RES_DIGITS(RD), .REM_DIGITS(MD)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .op(op),
        .busy(busy), .done(done), .err(err), .ovf(ovf), .lop(lop),
        .seg_sign(seg_sign), .seg_res(seg_res), .seg_rem(seg_rem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    // Expected display of value v on nd digits, ones digit in the low bits.
    function automatic logic [31:0] exp_field(input int v, input int nd, input bit blank, input bit minus);
        logic [31:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < nd; i++) begin
            if (blank)      r[7*i +: 7] = 7'b1111111;
            else if (minus) r[7*i +: 7] = 7'b0111111;
            else            r[7*i +: 7] = segtab[(v / p) % 10];
            p = p * 10;
        end
`ifdef LEADING_ZERO_BLANK_EN
        p = 1;
        for (int i = 1; i < nd; i++) begin
            p = p * 10;
            if (!blank && !minus && v < p) r[7*i +: 7] = 7'b1111111;
        end
`endif
        return r;
    endfunction

    function automatic int pw(input int n);
        int p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic [1:0] top);
        int v, r, lat, n;
        bit neg, er, ovr, ovm;
        v = 0; r = 0; neg = 0; er = 0;
        case (top)
            2'b00: v = ta + tb2;
            2'b01: begin v = (ta >= tb2) ? ta - tb2 : tb2 - ta; neg = (ta < tb2); end
            2'b10: v = ta * tb2;
            default: if (tb2 == 0) er = 1; else begin v = ta / tb2; r = ta % tb2; end
        endcase
        ovr = (v >= pw(RD));
        ovm = (r >= pw(MD));
        lat = ((top == 2'b10) || (top == 2'b11 && tb2 != 0)) ? W + 2*W + 1 : 1 + 2*W + 1;

        @(negedge clk);
        a = ta; b = tb2; op = top; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); op = 2'($urandom);
        chk($sformatf("busy op%0d", top), busy, 1);
        n = 0;
        while (!done && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("latency op%0d a%0d b%0d", top, ta, tb2), n, lat);
        chk("err", err, er);
        chk("ovf", ovf, ovr | ovm);
        chk("lop", lop, top);
        chk("seg_sign", seg_sign, (neg && !er) ? 7'b0111111 : 7'b1111111);
        chk($sformatf("seg_res op%0d a%0d b%0d", top, ta, tb2), seg_res, exp_field(v, RD, er, ovr));
        chk($sformatf("seg_rem op%0d a%0d b%0d", top, ta, tb2), seg_rem,
            exp_field(r, MD, er || top != 2'b11, ovm));
        @(posedge clk); #1;
        chk("done pulse width", done, 0);
        chk("seg_res hold", seg_res, exp_field(v, RD, er, ovr));
    endtask

    initial begin
        int n;
        bit seen;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; op = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst ovf", ovf, 0);
        chk("rst lop", lop, 0);
        chk("rst seg_sign", seg_sign, 7'h7f);
        chk("rst seg_res", seg_res, 21'h1fffff);
        chk("rst seg_rem", seg_rem, 14'h3fff);
        @(negedge clk) rst = 1'b0;

        run_op(4'd9, 4'd7, 2'b00);
        run_op(4'd3, 4'd12, 2'b01);
        run_op(4'd15, 4'd15, 2'b10);
        run_op(4'd14, 4'd4, 2'b11);
        run_op(4'd5, 4'd0, 2'b11);

        // Reset in the middle of a multiply.
        @(negedge clk);
        a = 4'd15; b = 4'd15; op = 2'b10; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst busy", busy, 0);
        chk("midrst err", err, 0);
        chk("midrst lop", lop, 0);
        chk("midrst seg_res", seg_res, 21'h1fffff);
        chk("midrst seg_rem", seg_rem, 14'h3fff);
        @(negedge clk) rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        chk("midrst no done", seen, 0);
        run_op(4'd6, 4'd7, 2'b10);

        // Start held high: back-to-back adds, each with its own latched operands.
        @(negedge clk);
        a = 4'd1; b = 4'd2; op = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        a = 4'd7; b = 4'd8;
        n = 0;
        while (!done && n < 60) begin @(posedge clk); #1; n++; end
        chk("b2b first latency", n, 10);
        chk("b2b first res", seg_res, exp_field(3, RD, 0, 0));
        @(posedge clk); #1;
        start = 1'b0; a = 4'd0; b = 4'd0;
        chk("b2b second started", busy, 1);
        n = 0;
        while (!done && n < 60) begin @(posedge clk); #1; n++; end
        chk("b2b done spacing", n + 1, 11);
        chk("b2b second res", seg_res, exp_field(15, RD, 0, 0));

        // Boundaries: zero, max add, zero dividend, divide by one, 0/0.
        run_op(4'd0, 4'd0, 2'b00);
        run_op(4'd15, 4'd15, 2'b00);
        run_op(4'd0, 4'd15, 2'b01);
        run_op(4'd15, 4'd1, 2'b11);
        run_op(4'd0, 4'd5, 2'b11);
        run_op(4'd0, 4'd0, 2'b11);

        repeat (20) run_op(W'($urandom), W'($urandom), 2'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
